axis_deltasigma_output: RTL and testbench

//  AXI4-Stream slave to 1-bit delta-sigma bitstream transmitter. Transmit-side counterpart of the delta-sigma input block.

---
 rtl/axis_deltasigma_output.sv | 90 +++++++++
 tb/tb_axis_deltasigma_output.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_deltasigma_output.sv
// AXI4-Stream PCM sample to 1-bit first-order delta-sigma bitstream.
// Error-feedback accumulator carry is the output bit, one bit per CLK_DIV clocks.
module axis_deltasigma_output #(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter bit TWOS_COMPL       = 1'b1,
  parameter int CLK_DIV          = 8
) (
  input  logic                        s_axis_aclk,
  input  logic                        s_axis_areset,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        enable,
  output logic                        ds_clk_o,
  output logic                        ds_data_o,
  output logic                        underrun
);

  localparam int W  = AXIS_TDATA_WIDTH;
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);
  localparam logic [W-1:0]  MID  =
    TWOS_COMPL ? {1'b1, {(W-1){1'b0}}} : '0;

  logic [CW-1:0] div_cnt;
  logic [CW-1:0] next_cnt;
  logic [W-1:0]  acc;
  logic [W-1:0]  hold;
  logic [W-1:0]  cur;
  logic          hold_full;
  logic [W-1:0]  u;
  logic [W-1:0]  src;
  logic [W:0]    sum;
  logic          tick;
  logic          accept;

  // Offset-binary view of the sample: signed zero maps to half scale.
  always_comb begin
    u = s_axis_tdata;
    if (TWOS_COMPL) u[W-1] = ~s_axis_tdata[W-1];
  end

  assign s_axis_tready = ~hold_full;
  assign accept   = s_axis_tvalid & ~hold_full;
  assign tick     = enable & (div_cnt == LAST);
  assign next_cnt = tick ? '0 : div_cnt + 1'b1;
  assign src      = hold_full ? hold : cur;
  assign sum      = {1'b0, acc} + {1'b0, src};

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      div_cnt   <= '0;
      acc       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      cur       <= MID;
      ds_data_o <= 1'b0;
      ds_clk_o  <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (enable) begin
        div_cnt  <= next_cnt;
        ds_clk_o <= (next_cnt >= HALF);
        if (tick) begin
          acc       <= sum[W-1:0];
          ds_data_o <= sum[W];
          if (hold_full) begin
            cur       <= hold;
            hold_full <= 1'b0;
          end else begin
            underrun <= 1'b1;
          end
        end
      end else begin
        div_cnt   <= '0;
        acc       <= '0;
        ds_clk_o  <= 1'b0;
        ds_data_o <= 1'b0;
      end
      // tready is low whenever a tick could drain hold, so no conflict here.
      if (accept) begin
        hold      <= u;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_deltasigma_output.sv
// Bench for axis_deltasigma_output: random and directed streams
// checked against a queue-based arithmetic model, plus density counts.
module tb_axis_deltasigma_output;

  localparam int W   = 8;
  localparam int DIV = 4;
  localparam int FS  = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic         tvalid;
  logic         en;
  logic [W-1:0] tdata;
  logic         rdy0, dclk0, dd0, ur0;
  logic         rdy1, dclk1, dd1, ur1;

  always #5 clk = ~clk;

  axis_deltasigma_output #(
    .AXIS_TDATA_WIDTH(W), .TWOS_COMPL(1'b1), .CLK_DIV(DIV)
  ) dut_s (
    .s_axis_aclk(clk), .s_axis_areset(rst),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(rdy0), .enable(en),
    .ds_clk_o(dclk0), .ds_data_o(dd0), .underrun(ur0)
  );

  axis_deltasigma_output #(
    .AXIS_TDATA_WIDTH(W), .TWOS_COMPL(1'b0), .CLK_DIV(DIV)
  ) dut_u (
    .s_axis_aclk(clk), .s_axis_areset(rst),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(rdy1), .enable(en),
    .ds_clk_o(dclk1), .ds_data_o(dd1), .underrun(ur1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  bit sel;
  int m_phase, m_acc, m_last;
  int m_pend[$];
  bit m_clk, m_data, m_under, m_tick;
  bit cnt_on;
  int ones, bits, unders;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
  endtask

  function automatic int conv(input int d);
    return sel ? d : ((d + FS / 2) % FS);
  endfunction

  function automatic int mid();
    return sel ? 0 : FS / 2;
  endfunction

  function automatic bit o_rdy();  return sel ? rdy1  : rdy0;  endfunction
  function automatic bit o_clk();  return sel ? dclk1 : dclk0; endfunction
  function automatic bit o_data(); return sel ? dd1   : dd0;   endfunction
  function automatic bit o_ur();   return sel ? ur1   : ur0;   endfunction

  task automatic model_reset();
    m_phase = 0; m_acc = 0; m_last = mid();
    m_pend.delete();
    m_clk = 0; m_data = 0; m_under = 0; m_tick = 0;
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    bit r, e, v, take;
    int d, src, tot;
    r = rst; e = en; v = tvalid; d = int'(tdata);
    take = v && (m_pend.size() == 0);
    @(posedge clk);
    m_tick = 0;
    if (r) begin
      model_reset();
    end else begin
      m_under = 0;
      if (e) begin
        m_tick  = (m_phase == DIV - 1);
        m_phase = m_tick ? 0 : m_phase + 1;
        m_clk   = (m_phase >= DIV / 2);
        if (m_tick) begin
          if (m_pend.size() > 0) m_last = m_pend.pop_front();
          else m_under = 1;
          src    = m_last;
          tot    = m_acc + src;
          m_data = (tot >= FS);
          m_acc  = tot % FS;
        end
      end else begin
        m_phase = 0; m_acc = 0; m_clk = 0; m_data = 0;
      end
      if (take) m_pend.push_back(conv(d));
    end
    #1;
    chk("tready", int'(o_rdy()), int'(m_pend.size() == 0));
    chk("ds_clk", int'(o_clk()), int'(m_clk));
    chk("ds_data", int'(o_data()), int'(m_data));
    chk("underrun", int'(o_ur()), int'(m_under));
    if (cnt_on) begin
      if (m_tick) begin
        bits++;
        ones += int'(o_data());
      end
      unders += int'(o_ur());
    end
  endtask

  task automatic run_ticks(input int n);
    int seen = 0;
    int budget = n * DIV + DIV + 2;
    while (seen < n && budget > 0) begin
      step();
      if (m_tick) seen++;
      budget--;
    end
    if (seen < n) chk("tick_timeout", seen, n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic density(input string tag, input int d,
                         input int exp_ones, input int exp_ur);
    en = 1'b1; tvalid = 1'b1; tdata = W'(d);
    do_reset();
    run_ticks(4);
    ones = 0; bits = 0; unders = 0; cnt_on = 1;
    run_ticks(FS);
    cnt_on = 0;
    chk({tag, "_bits"}, bits, FS);
    chk({tag, "_ones"}, ones, exp_ones);
    chk({tag, "_underruns"}, unders, exp_ur);
  endtask

  task automatic random_run(input int cycles);
    en = 1'b1; tvalid = 1'b0; tdata = '0;
    do_reset();
    for (int i = 0; i < cycles; i++) begin
      tvalid = ($urandom_range(0, 3) != 0);
      tdata  = W'($urandom);
      if ($urandom_range(0, 59) == 0) en = ~en;
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    int wait_n;
    sel = 0; cnt_on = 0;
    rst = 1'b1; en = 1'b1; tvalid = 1'b0; tdata = '0;
    model_reset();

    // Reset then idle: first tick underruns, mid-scale gives 0,1,0,1.
    do_reset();
    chk("rst_tready", int'(rdy0), 1);
    chk("rst_clk", int'(dclk0), 0);
    chk("rst_data", int'(dd0), 0);
    chk("rst_under", int'(ur0), 0);
    run_ticks(1);
    chk("idle_first_under", int'(ur0), 1);
    chk("idle_first_bit", int'(dd0), 0);
    run_ticks(1);
    chk("idle_second_bit", int'(dd0), 1);

    // Signed densities.
    density("zero", 8'h00, 128, 0);
    density("pos_full", 8'h7F, 255, 0);
    density("neg_full", 8'h80, 0, 0);

    // Single sample 0x40 then idle: u=0xC0, 3/4 density, constant underrun.
    en = 1'b1; tvalid = 1'b0;
    do_reset();
    tvalid = 1'b1; tdata = 8'h40;
    step();
    tvalid = 1'b0;
    run_ticks(4);
    ones = 0; bits = 0; unders = 0; cnt_on = 1;
    run_ticks(FS);
    cnt_on = 0;
    chk("one_shot_ones", ones, 192);
    chk("one_shot_underruns", unders, FS);

    // tvalid rises on a tick cycle with hold empty.
    en = 1'b1; tvalid = 1'b0;
    do_reset();
    run_ticks(2);
    wait_n = 0;
    while (m_phase != DIV - 1 && wait_n < 2 * DIV) begin
      step();
      wait_n++;
    end
    chk("t5_align", m_phase, DIV - 1);
    tvalid = 1'b1; tdata = 8'h7F;
    step();
    tvalid = 1'b0;
    chk("t5_under", int'(ur0), 1);
    chk("t5_held", int'(rdy0), 0);
    run_ticks(1);
    chk("t5_next_under", int'(ur0), 0);
    chk("t5_drained", int'(rdy0), 1);

    // Enable drop mid-bit keeps the held sample.
    tvalid = 1'b1; tdata = 8'h00;
    run_ticks(3);
    step();
    en = 1'b0; tvalid = 1'b1; tdata = 8'h7F;
    step();
    step();
    tvalid = 1'b0;
    chk("dis_clk", int'(dclk0), 0);
    chk("dis_data", int'(dd0), 0);
    chk("dis_held", int'(rdy0), 0);
    en = 1'b1;
    repeat (DIV - 1) step();
    chk("reen_no_tick_yet", int'(rdy0), 0);
    step();
    chk("reen_tick_drain", int'(rdy0), 1);
    chk("reen_first_bit", int'(dd0), 0);
    chk("reen_no_under", int'(ur0), 0);
    step();

    // Reset mid-stream discards the held sample.
    tvalid = 1'b1; tdata = 8'h11;
    step();
    tvalid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_tready", int'(rdy0), 1);
    chk("mid_rst_clk", int'(dclk0), 0);
    chk("mid_rst_data", int'(dd0), 0);

    random_run(3000);

    // Unsigned instance.
    sel = 1;
    model_reset();
    density("u_full", 8'hFF, 255, 0);
    density("u_zero", 8'h00, 0, 0);
    density("u_q1", 8'h40, 64, 0);
    random_run(3000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
